// File: rtl/aquila_dbus_router.sv
// Aquila data-bus router: tag decode, in-flight target tracking, response mux.
// Optional watchdog with FLUSH state and pending buffer under DBUS_WATCHDOG_EN.
module aquila_dbus_router #(
  parameter int XLEN           = 32,
  parameter int N_PORTS        = 4,
  parameter int TAG_MSB        = 31,
  parameter int TAG_LSB        = 28,
  parameter int TW             = TAG_MSB - TAG_LSB + 1,
  parameter logic [N_PORTS*TW-1:0] REGION_TAG = {4'hF, 4'hC, 4'h0, 4'h0},
  parameter logic [N_PORTS-1:0]    REGION_EN  = 4'b1101,
  parameter int DEFAULT_PORT   = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    p_strobe_i,
  input  logic [XLEN-1:0]         p_addr_i,
  input  logic                    p_rw_i,
  input  logic [XLEN/8-1:0]       p_byte_enable_i,
  input  logic [XLEN-1:0]         p_data_i,
  output logic [XLEN-1:0]         p_data_o,
  output logic                    p_ready_o,
  output logic                    p_error_o,
  output logic                    p_ext_o,
  output logic [N_PORTS-1:0]      t_strobe_o,
  output logic [XLEN-1:0]         t_addr_o,
  output logic                    t_rw_o,
  output logic [XLEN/8-1:0]       t_byte_enable_o,
  output logic [XLEN-1:0]         t_data_o,
  input  logic [N_PORTS*XLEN-1:0] t_data_i,
  input  logic [N_PORTS-1:0]      t_ready_i
);

  localparam int SW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

`ifdef DBUS_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CLIM = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FLUSH} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_BUSY} state_t;
`endif

  state_t            r_state, w_state_n;
  logic [SW-1:0]     r_sel;
  logic [SW-1:0]     w_dec_sel;
  logic              w_hit;
  logic [XLEN-1:0]   w_rdata;
  logic              w_rdy;
  logic              w_acc;
  logic [SW-1:0]     w_src_sel;
  logic [XLEN-1:0]   w_src_addr;
  logic              w_src_rw;
  logic [XLEN/8-1:0] w_src_be;
  logic [XLEN-1:0]   w_src_data;

`ifdef DBUS_WATCHDOG_EN
  logic [CW-1:0]     r_cnt, w_cnt_n;
  logic              r_pend_v, w_pend_set, w_pend_clr;
  logic [XLEN-1:0]   r_pend_addr;
  logic              r_pend_rw;
  logic [XLEN/8-1:0] r_pend_be;
  logic [XLEN-1:0]   r_pend_data;
  logic [SW-1:0]     r_pend_sel;
  logic              w_fl_exit;
`endif

  // Lowest-index enabled matching tag wins.
  always_comb begin
    w_dec_sel = SW'(DEFAULT_PORT);
    w_hit     = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!w_hit && REGION_EN[i] &&
          REGION_TAG[i*TW +: TW] == p_addr_i[TAG_MSB:TAG_LSB]) begin
        w_dec_sel = SW'(i);
        w_hit     = 1'b1;
      end
    end
  end

  assign p_ext_o = (w_dec_sel != '0);

  always_comb begin
    w_rdata = '0;
    w_rdy   = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (SW'(i) == r_sel) begin
        w_rdata = t_data_i[i*XLEN +: XLEN];
        w_rdy   = t_ready_i[i];
      end
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_acc      = 1'b0;
    w_src_sel  = w_dec_sel;
    w_src_addr = p_addr_i;
    w_src_rw   = p_rw_i;
    w_src_be   = p_byte_enable_i;
    w_src_data = p_data_i;
    p_ready_o  = 1'b0;
    p_error_o  = 1'b0;
    p_data_o   = '0;
`ifdef DBUS_WATCHDOG_EN
    w_cnt_n    = r_cnt;
    w_pend_set = 1'b0;
    w_pend_clr = 1'b0;
    w_fl_exit  = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (p_strobe_i) begin
          w_acc     = 1'b1;
          w_state_n = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_rdy) begin
          p_ready_o = 1'b1;
          p_data_o  = w_rdata;
          if (p_strobe_i) w_acc = 1'b1;
          else            w_state_n = S_IDLE;
`ifdef DBUS_WATCHDOG_EN
        end else if (r_cnt == CLIM) begin
          p_ready_o = 1'b1;
          p_error_o = 1'b1;
          w_cnt_n   = '0;
          w_state_n = S_FLUSH;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
`endif
        end
      end
`ifdef DBUS_WATCHDOG_EN
      S_FLUSH: begin
        w_fl_exit = w_rdy || (r_cnt == CLIM);
        w_cnt_n   = r_cnt + 1'b1;
        if (w_fl_exit) begin
          w_cnt_n   = '0;
          w_state_n = S_IDLE;
          if (r_pend_v) begin
            w_acc      = 1'b1;
            w_pend_clr = 1'b1;
            w_src_sel  = r_pend_sel;
            w_src_addr = r_pend_addr;
            w_src_rw   = r_pend_rw;
            w_src_be   = r_pend_be;
            w_src_data = r_pend_data;
            w_state_n  = S_BUSY;
          end else if (p_strobe_i) begin
            w_acc     = 1'b1;
            w_state_n = S_BUSY;
          end
        end else if (p_strobe_i && !r_pend_v) begin
          w_pend_set = 1'b1;
        end
      end
`endif
      default: w_state_n = S_IDLE;
    endcase
`ifdef DBUS_WATCHDOG_EN
    if (w_acc) w_cnt_n = '0;
`endif
    if (rst_i) begin
      w_acc     = 1'b0;
      p_ready_o = 1'b0;
      p_error_o = 1'b0;
      p_data_o  = '0;
    end
  end

  assign t_strobe_o      = w_acc ? (N_PORTS'(1) << w_src_sel) : '0;
  assign t_addr_o        = w_acc ? w_src_addr : '0;
  assign t_rw_o          = w_acc & w_src_rw;
  assign t_byte_enable_o = w_acc ? w_src_be : '0;
  assign t_data_o        = w_acc ? w_src_data : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_acc) r_sel <= w_src_sel;
    end
  end

`ifdef DBUS_WATCHDOG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
      r_pend_rw   <= 1'b0;
      r_pend_be   <= '0;
      r_pend_data <= '0;
      r_pend_sel  <= '0;
    end else begin
      r_cnt <= w_cnt_n;
      if (w_pend_clr) r_pend_v <= 1'b0;
      if (w_pend_set) begin
        r_pend_v    <= 1'b1;
        r_pend_addr <= p_addr_i;
        r_pend_rw   <= p_rw_i;
        r_pend_be   <= p_byte_enable_i;
        r_pend_data <= p_data_i;
        r_pend_sel  <= w_dec_sel;
      end
    end
  end
`endif

endmodule

// File: tb/tb_aquila_dbus_router.sv
// Directed bench for aquila_dbus_router: decode, latency, back-to-back,
// reset mid-access, and watchdog or no-watchdog behaviour per build.
module tb_aquila_dbus_router;

  logic         clk = 1'b0;
  logic         rst;
  logic         strobe;
  logic [31:0]  addr;
  logic         rw;
  logic [3:0]   be;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         ready;
  logic         err;
  logic         ext;
  logic [3:0]   tstb;
  logic [31:0]  taddr;
  logic         trw;
  logic [3:0]   tbe;
  logic [31:0]  tdata;
  logic [127:0] tdin;
  logic [3:0]   trdy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aquila_dbus_router #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .p_strobe_i(strobe), .p_addr_i(addr), .p_rw_i(rw),
    .p_byte_enable_i(be), .p_data_i(wdata),
    .p_data_o(rdata), .p_ready_o(ready), .p_error_o(err), .p_ext_o(ext),
    .t_strobe_o(tstb), .t_addr_o(taddr), .t_rw_o(trw),
    .t_byte_enable_o(tbe), .t_data_o(tdata),
    .t_data_i(tdin), .t_ready_i(trdy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    strobe = 0; addr = 0; rw = 0; be = 0; wdata = 0;
    tdin = '0; trdy = '0;
  endtask

  logic [31:0] dec_addr [5] = '{32'h0000_0010, 32'h8000_0000,
                                32'hC000_0004, 32'hF000_0000,
                                32'h4000_0000};
  logic [3:0]  dec_exp  [5] = '{4'b0001, 4'b0010, 4'b0100,
                                4'b1000, 4'b0010};
  logic        seen_rdy;
  logic        seen_err;

  initial begin
    idle_in();
    rst = 1;
    cyc();
    cyc();
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_strobe", {28'b0, tstb}, 32'd0);
    rst = 0;

    // Decode table; each access completed by its target one cycle later.
    for (int i = 0; i < 5; i++) begin
      cyc();
      strobe = 1; addr = dec_addr[i]; rw = (i == 0); be = 4'hF;
      wdata = 32'hA5A5_0000 + i;
      #2;
      chk($sformatf("dec_stb%0d", i), {28'b0, tstb}, {28'b0, dec_exp[i]});
      chk($sformatf("dec_ext%0d", i), {31'b0, ext}, {31'b0, i != 0});
      if (i == 0) begin
        chk("acc_rw", {31'b0, trw}, 32'd1);
        chk("acc_wdata", tdata, 32'hA5A5_0000);
        chk("acc_addr", taddr, 32'h0000_0010);
      end
      cyc();
      strobe = 0; trdy = dec_exp[i];
      #2;
      chk($sformatf("dec_rdy%0d", i), {31'b0, ready}, 32'd1);
      if (i == 0) begin
        chk("idle_rw", {31'b0, trw}, 32'd0);
        chk("idle_addr", taddr, 32'd0);
      end
      cyc();
      idle_in();
    end

    // Port 2 answers three cycles after strobe.
    cyc();
    strobe = 1; addr = 32'hC000_0004;
    cyc();
    idle_in();
    #2;
    chk("lat_rdy1", {31'b0, ready}, 32'd0);
    chk("lat_dat1", rdata, 32'd0);
    cyc();
    #2;
    chk("lat_rdy2", {31'b0, ready}, 32'd0);
    cyc();
    trdy = 4'b0100; tdin[64 +: 32] = 32'hDEAD_BEEF;
    #2;
    chk("lat_rdy3", {31'b0, ready}, 32'd1);
    chk("lat_dat3", rdata, 32'hDEAD_BEEF);
    cyc();
    idle_in();
    #2;
    chk("lat_after", {31'b0, ready}, 32'd0);

    // Back-to-back: port 0 then port 3.
    cyc();
    strobe = 1; addr = 32'h0000_0100;
    cyc();
    strobe = 1; addr = 32'hF000_0008; trdy = 4'b0001;
    tdin[0 +: 32] = 32'h1111_2222;
    #2;
    chk("b2b_rdy0", {31'b0, ready}, 32'd1);
    chk("b2b_dat0", rdata, 32'h1111_2222);
    chk("b2b_stb3", {28'b0, tstb}, 32'b1000);
    cyc();
    idle_in();
    trdy = 4'b1000; tdin[96 +: 32] = 32'h3333_4444;
    #2;
    chk("b2b_rdy3", {31'b0, ready}, 32'd1);
    chk("b2b_dat3", rdata, 32'h3333_4444);
    chk("b2b_nostb", {28'b0, tstb}, 32'd0);
    cyc();
    idle_in();

    // Reset in the middle of a port-1 read.
    cyc();
    strobe = 1; addr = 32'h8000_0000;
    cyc();
    idle_in();
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    #2;
    chk("mrst_rdy", {31'b0, ready}, 32'd0);
    chk("mrst_err", {31'b0, err}, 32'd0);
    chk("mrst_stb", {28'b0, tstb}, 32'd0);
    chk("mrst_dat", rdata, 32'd0);
    cyc();
    trdy = 4'b0010; tdin[32 +: 32] = 32'h5555_6666;
    #2;
    chk("mrst_late", {31'b0, ready}, 32'd0);
    chk("mrst_ldat", rdata, 32'd0);
    cyc();
    idle_in();

`ifdef DBUS_WATCHDOG_EN
    // Port 2 hangs; error at cycle 8, buffered strobe issued at cycle 12.
    cyc();
    strobe = 1; addr = 32'hC000_0000;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      idle_in();
      tdin[64 +: 32] = 32'h0BAD_0BAD;
    end
    #2;
    chk("wd_c7", {31'b0, ready}, 32'd0);
    cyc();
    #2;
    chk("wd_rdy", {31'b0, ready}, 32'd1);
    chk("wd_err", {31'b0, err}, 32'd1);
    chk("wd_dat", rdata, 32'd0);
    cyc();
    #2;
    chk("wd_fl9", {31'b0, ready}, 32'd0);
    cyc();
    strobe = 1; addr = 32'h0000_0040;
    #2;
    chk("wd_buf", {28'b0, tstb}, 32'd0);
    cyc();
    strobe = 0; addr = 0;
    cyc();
    trdy = 4'b0100;
    #2;
    chk("wd_stale", {31'b0, ready}, 32'd0);
    chk("wd_issue", {28'b0, tstb}, 32'b0001);
    chk("wd_iaddr", taddr, 32'h0000_0040);
    cyc();
    trdy = 4'b0001; tdin[0 +: 32] = 32'h7777_8888;
    #2;
    chk("wd_prdy", {31'b0, ready}, 32'd1);
    chk("wd_pdat", rdata, 32'h7777_8888);
    chk("wd_perr", {31'b0, err}, 32'd0);
    cyc();
    idle_in();
`else
    // No watchdog: a silent target stalls the router indefinitely.
    cyc();
    strobe = 1; addr = 32'hC000_0000;
    cyc();
    idle_in();
    seen_rdy = 0;
    seen_err = 0;
    for (int c = 0; c < 2000; c++) begin
      #2;
      seen_rdy |= ready;
      seen_err |= err;
      cyc();
    end
    chk("nowd_rdy", {31'b0, seen_rdy}, 32'd0);
    chk("nowd_err", {31'b0, seen_err}, 32'd0);
    trdy = 4'b0100; tdin[64 +: 32] = 32'hCAFE_F00D;
    #2;
    chk("nowd_late", {31'b0, ready}, 32'd1);
    chk("nowd_ldat", rdata, 32'hCAFE_F00D);
    cyc();
    idle_in();
`endif

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aquila_dbus_router.md
# aquila_dbus_router

Parametrised data-bus router between the Aquila core data port and N memory-mapped targets: TCM, D-cache, device port, system devices, and any future slaves. It decodes a configurable address tag field into a target select and forwards each request to exactly one target. It tracks the in-flight target so that the response mux stays stable until the target answers. Optionally, a watchdog aborts hung accesses with an error response.

## Interface
- XLEN, 32: data/address width.
- N_PORTS, 4: number of target ports (2..16).
- TAG_MSB, 31 / TAG_LSB, 28: address bits used for decode; TW = TAG_MSB-TAG_LSB+1.
- REGION_TAG, {4'hF,4'hC,4'h0,4'h0}: packed N_PORTS×TW. Field i is the tag for port i. Port i is active only if bit i of REGION_EN is set.
- REGION_EN, 4'b1101: per-port decode enable.
- DEFAULT_PORT, 1: target when no enabled tag matches.
- TIMEOUT_CYCLES, 1024: watchdog limit (≥2).
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- p_strobe_i  in  1  request pulse from core.
- p_addr_i  in  XLEN  request address.
- p_rw_i  in  1  1 = write.
- p_byte_enable_i  in  XLEN/8  byte lanes.
- p_data_i  in  XLEN  write data.
- p_data_o  out  XLEN  read data of selected target.
- p_ready_o  out  1  response strobe.
- p_error_o  out  1  response is a timeout abort.
- p_ext_o  out  1  combinational: decoded target of p_addr_i ≠ port 0.
- t_strobe_o  out  N_PORTS  one-hot request pulse.
- t_addr_o / t_rw_o / t_byte_enable_o / t_data_o  out  XLEN/1/XLEN/8/XLEN  broadcast request fields.
- t_data_i  in  N_PORTS×XLEN  packed target read data.
- t_ready_i  in  N_PORTS  target response strobes.

## Operation
- Decode: the lowest-index enabled port whose tag equals p_addr_i[TAG_MSB:TAG_LSB] wins; otherwise DEFAULT_PORT.
- States:
  - IDLE
  - BUSY
  - FLUSH (watchdog build only)
- Accept rule: a strobe is accepted in IDLE, or in BUSY in the same cycle that p_ready_o=1 (back-to-back). On accept:
  - t_strobe_o[sel] pulses in the same cycle.
  - Request fields are driven combinationally from p_*.
  - sel_r ← sel; the state goes to BUSY.
- BUSY:
  - p_ready_o = t_ready_i[sel_r]; p_data_o = t_data_i[sel_r].
  - On ready with no new strobe → IDLE.
  - A strobe in BUSY without ready is a protocol violation: it is not forwarded and is dropped.
- IDLE: t_ready_i is ignored; p_ready_o=0; p_data_o=0.
- t_rw_o is gated: t_rw_o = p_rw_i only in an accept cycle, else 0. t_data_o and t_addr_o are zero outside accept cycles.
- Reset (any state, including mid-access):
  - State = IDLE; sel_r = 0; counter = 0; pending buffer = empty.
  - All outputs are 0 except p_ext_o, which stays combinational.
  - The in-flight target's later ready is ignored because the router is in IDLE.

## Timing
- Request forwarding latency: 0 cycles. Targets respond no earlier than 1 cycle after the strobe.
- Response latency through the router: 0 cycles, from t_ready_i to p_ready_o.
- Back-to-back throughput: one access per cycle when targets answer in 1 cycle.
- Watchdog:
  - The counter clears on accept and increments every BUSY cycle without ready.
  - When the count reaches TIMEOUT_CYCLES-1, the router emits p_ready_o=1, p_error_o=1, p_data_o=0 for 1 cycle and enters FLUSH.
  - In the error cycle, a new strobe is not accepted.
- FLUSH:
  - The router waits for t_ready_i[sel_r] (stale response, swallowed) or for a further TIMEOUT_CYCLES cycles, then → IDLE.
  - A strobe arriving in FLUSH is latched into a 1-entry pending buffer (addr, rw, be, data, sel). It is issued as the accept in the cycle FLUSH exits.
  - Further strobes while the buffer is full are dropped.
- Simultaneous events:
  - Ready in the same cycle the counter hits its limit: the ready wins, with no error.
  - Stale ready in the same cycle as the FLUSH limit: treated as the same exit.

## Configuration
- DBUS_WATCHDOG_EN defined: the watchdog counter, FLUSH state, pending buffer and p_error_o behave as above.
- Not defined:
  - No counter, FLUSH state or buffer.
  - p_error_o is tied 0.
  - BUSY waits indefinitely for ready.

## Test plan
- Decode with default params:
  - Read 0x0000_0010 → t_strobe_o=4'b0001, p_ext_o=0.
  - 0x8000_0000 → 4'b0010.
  - 0xC000_0004 → 4'b0100.
  - 0xF000_0000 → 4'b1000.
  - 0x4000_0000 → 4'b0010 (default).
- Port 2 answers data 0xDEAD_BEEF 3 cycles after strobe:
  - p_ready_o=1 and p_data_o=0xDEAD_BEEF exactly in that cycle.
  - p_data_o=0 in the cycles before.
- Back-to-back:
  - Strobe to port 0 at cycle 0; ready at cycle 1 with a new strobe to port 3.
  - Port 3 pulses at cycle 1; the response from port 3 at cycle 2 is routed correctly.
- Watchdog with TIMEOUT_CYCLES=8:
  - Port 2 never answers → p_ready_o=1, p_error_o=1 at cycle 8.
  - A strobe at cycle 10 to port 0 is buffered and issued when port 2's stale ready arrives at cycle 12.
  - The stale ready is not seen on p_ready_o.
- Reset mid-access:
  - rst_i at cycle 2 of a pending port-1 read → all outputs 0 on the next cycle.
  - Port 1's ready at cycle 4 produces no p_ready_o.
- Build without DBUS_WATCHDOG_EN:
  - Target silent for 2000 cycles → p_ready_o stays 0 and p_error_o stays 0.
